// File: rtl/reg_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reg_chain_ctrl_if
// Description : Valid/ready handshake bundle for the elastic register chain.
//               Carries the producer side (in_*) and consumer side (out_*)
//               of the pipe in one interface.
//               master : environment side (drives in_valid, in_data, out_ready)
//               slave  : controller side  (drives in_ready, out_valid, out_data)
// Ports       : none (signal bundle only)
// Revision    : 1.0  initial release
// ============================================================================
interface reg_chain_ctrl_if #(
  parameter int REG_WIDTH = 4
);
  logic                 in_valid;
  logic [REG_WIDTH-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic [REG_WIDTH-1:0] out_data;
  logic                 out_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    output out_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    input  out_ready
  );
endinterface
`default_nettype wire

// File: rtl/reg_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reg_chain_ctrl
// Description : Elastic controller for a chain of CHAIN_COUNT registers of
//               REG_WIDTH bits. Keeps one valid bit per stage and produces a
//               per-stage load enable so the chain behaves as a stallable,
//               bubble-collapsing FIFO-like pipe between a producer and a
//               consumer that may apply backpressure.
// Ports       : clk       rising-edge clock
//               rst       synchronous active-high reset
//               bus       handshake bundle (slave modport):
//                           in_valid/in_data/in_ready   producer side
//                           out_valid/out_data/out_ready consumer side
//               flush     synchronous clear of all stage valid bits
//               stage_en  per-stage load enable
//               count     number of valid stages
// Revision    : 1.0  initial release
// ============================================================================
module reg_chain_ctrl #(
  parameter  int REG_WIDTH   = 4,
  parameter  int CHAIN_COUNT = 3,
  localparam int CNT_W       = $clog2(CHAIN_COUNT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_chain_ctrl_if.slave        bus,
  input  logic                   flush,
  output logic [CHAIN_COUNT-1:0] stage_en,
  output logic [CNT_W-1:0]       count
);

  localparam int LAST = CHAIN_COUNT - 1;

  // Stage state: stage 0 is the input side, stage LAST feeds out_data.
  logic [CHAIN_COUNT-1:0]                r_valid;
  logic [CHAIN_COUNT-1:0][REG_WIDTH-1:0] r_data;
  logic [CNT_W-1:0]                      r_count;

  // move[k]: stage k can hand its word on (to stage k+1, or to the consumer
  // for the last stage). An empty stage always "moves", which is what lets
  // bubbles collapse forward even while the consumer stalls.
  logic [CHAIN_COUNT-1:0] w_move;
  logic [CHAIN_COUNT-1:0] w_stage_en;
  logic                   w_in_ready;
  logic                   w_in_xfer;
  logic                   w_out_xfer;

  always_comb begin
    w_move       = '0;
    w_move[LAST] = r_valid[LAST] ? bus.out_ready : 1'b1;
    for (int k = LAST - 1; k >= 0; k--) begin
      w_move[k] = ~r_valid[k+1] | w_move[k+1];
    end
  end

  // in_ready is combinational from out_ready through the move chain; there is
  // deliberately no skid buffer, so a full pipe accepts exactly when it pops.
  // A flush cycle blocks both acceptance and internal movement.
  assign w_in_ready = ~flush & (~r_valid[0] | w_move[0]);
  assign w_in_xfer  = bus.in_valid & w_in_ready;
  assign w_out_xfer = r_valid[LAST] & bus.out_ready;

  always_comb begin
    w_stage_en    = '0;
    w_stage_en[0] = w_in_xfer;
    for (int k = 1; k < CHAIN_COUNT; k++) begin
      w_stage_en[k] = ~flush & r_valid[k-1] & w_move[k-1];
    end
  end

  // Valid bits and occupancy. A stage stays valid if it is refilled or if it
  // could not hand off. For the last stage ~move equals "valid and stalled",
  // so the out-transfer is accounted for by the same expression.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (flush) begin
      // Any out-transfer in this cycle has already completed at the consumer;
      // the pipe simply empties.
      r_valid <= '0;
      r_count <= '0;
    end else begin
      for (int k = 0; k < CHAIN_COUNT; k++) begin
        r_valid[k] <= w_stage_en[k] | (r_valid[k] & ~w_move[k]);
      end
      case ({w_in_xfer, w_out_xfer})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Data registers: cleared by reset only; flush leaves contents in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else begin
      if (w_stage_en[0]) begin
        r_data[0] <= bus.in_data;
      end
      for (int k = 1; k < CHAIN_COUNT; k++) begin
        if (w_stage_en[k]) begin
          r_data[k] <= r_data[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_valid[LAST];
  assign bus.out_data  = r_data[LAST];
  assign stage_en      = w_stage_en;
  assign count         = r_count;

endmodule
`default_nettype wire

// File: tb/tb_reg_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_chain_ctrl
// Description : Directed self-checking bench for reg_chain_ctrl
//               (REG_WIDTH=4, CHAIN_COUNT=3): reset, streaming, backpressure,
//               bubble collapse, full push+pop, flush and mid-stream reset.
// Ports       : none
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_chain_ctrl;

  localparam int REG_WIDTH   = 4;
  localparam int CHAIN_COUNT = 3;
  localparam int CNT_W       = $clog2(CHAIN_COUNT + 1);

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [CHAIN_COUNT-1:0] stage_en;
  logic [CNT_W-1:0]       count;

  int n_tests = 0;
  int n_fail  = 0;

  reg_chain_ctrl_if #(.REG_WIDTH(REG_WIDTH)) bus ();

  reg_chain_ctrl #(
    .REG_WIDTH  (REG_WIDTH),
    .CHAIN_COUNT(CHAIN_COUNT)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .flush   (flush),
    .stage_en(stage_en),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just past the next rising edge; inputs are changed here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  initial begin
    int cnt_exp [8];
    cnt_exp = '{0, 1, 2, 3, 3, 2, 1, 0};

    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;

    // ---------------- 1: reset ----------------
    step();
    step();
    rst = 1'b0;
    settle();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_count",     count,         0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_stage_en",  stage_en,      0);

    // ---------------- 2: stream 1..4 ----------------
    // Word accepted in cycle 0 shows at the output in cycle 3.
    bus.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = (c < 4);
      bus.in_data  = 4'(c + 1);
      settle();
      if (c < 4) check("str_in_ready", bus.in_ready, 1);
      check("str_out_valid", bus.out_valid, (c >= 3 && c <= 6) ? 1 : 0);
      if (c >= 3 && c <= 6) check("str_out_data", bus.out_data, c - 2);
      check("str_count", count, cnt_exp[c]);
      if (c == 0) check("str_stage_en0", stage_en, 3'b001);
      if (c == 1) check("str_stage_en1", stage_en, 3'b011);
      step();
    end

    // ---------------- 3: backpressure ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 4'(5 + i);
      settle();
      check("bp_fill_ready", bus.in_ready, 1);
      step();
    end
    bus.in_data = 4'h8;
    for (int i = 0; i < 2; i++) begin
      settle();
      check("bp_full_ready", bus.in_ready,  0);
      check("bp_full_count", count,         3);
      check("bp_full_head",  bus.out_data,  5);
      check("bp_full_en",    stage_en,      0);
      step();
    end
    bus.out_ready = 1'b1;
    settle();
    check("bp_pop_ready", bus.in_ready, 1);
    check("bp_out5",      bus.out_data, 5);
    step();
    bus.in_data = 4'h9;
    settle();
    check("bp_pop_ready", bus.in_ready, 1);
    check("bp_out6",      bus.out_data, 6);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("bp_drain_valid", bus.out_valid, 1);
      check("bp_drain_data",  bus.out_data,  7 + i);
      step();
    end
    settle();
    check("bp_empty_valid", bus.out_valid, 0);
    check("bp_empty_count", count,         0);

    // ---------------- 4: bubbles ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hA;
    step();
    bus.in_valid = 1'b0;
    settle();
    check("bub_idle1_en", stage_en, 3'b010);
    step();
    settle();
    check("bub_idle2_en", stage_en, 3'b100);
    step();
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hB;
    settle();
    check("bub_pushB_ready", bus.in_ready, 1);
    check("bub_pushB_en",    stage_en,     3'b001);
    step();
    bus.in_valid = 1'b0;
    settle();
    check("bub_collapse_en", stage_en, 3'b010);
    step();
    settle();
    // Stages 2 and 1 hold A and B; stage 0 empty.
    check("bub_count",     count,         2);
    check("bub_out_valid", bus.out_valid, 1);
    check("bub_out_data",  bus.out_data,  4'hA);
    check("bub_in_ready",  bus.in_ready,  1);
    check("bub_stalled_en", stage_en,     0);
    bus.out_ready = 1'b1;
    step();
    settle();
    check("bub_outB", bus.out_data, 4'hB);
    step();
    settle();
    check("bub_empty", bus.out_valid, 0);

    // ---------------- 5: full push+pop ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = 4'(1 + i);
      step();
    end
    bus.in_data   = 4'h4;
    bus.out_ready = 1'b1;
    settle();
    check("pp_count_full", count,         3);
    check("pp_in_ready",   bus.in_ready,  1);
    check("pp_out1",       bus.out_data,  1);
    check("pp_stage_en",   stage_en,      3'b111);
    step();
    bus.in_valid = 1'b0;
    settle();
    check("pp_count_kept", count, 3);
    for (int i = 0; i < 3; i++) begin
      settle();
      check("pp_drain", bus.out_data, 2 + i);
      step();
    end
    settle();
    check("pp_empty", bus.out_valid, 0);

    // ---------------- 6a: flush ----------------
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'hE;
    step();
    bus.in_data = 4'hF;
    step();
    bus.in_valid = 1'b0;
    step();
    // Head word E is presented while flush is asserted with out_ready high.
    flush         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'h7;
    bus.out_ready = 1'b1;
    settle();
    check("fl_in_ready",  bus.in_ready,  0);
    check("fl_stage_en",  stage_en,      0);
    check("fl_out_valid", bus.out_valid, 1);
    check("fl_out_data",  bus.out_data,  4'hE);
    check("fl_count_pre", count,         2);
    step();
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    settle();
    check("fl_count",     count,         0);
    check("fl_valid",     bus.out_valid, 0);
    check("fl_data_kept", bus.out_data,  4'hE);
    check("fl_in_ready2", bus.in_ready,  1);
    step();
    settle();
    check("fl_stays_empty", bus.out_valid, 0);

    // ---------------- 6b: reset mid-stream ----------------
    bus.in_valid = 1'b1;
    bus.in_data  = 4'hC;
    step();
    bus.in_data = 4'hD;
    step();
    bus.in_valid = 1'b0;
    step();
    settle();
    check("mr_pre_valid", bus.out_valid, 1);
    check("mr_pre_data",  bus.out_data,  4'hC);
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("mr_count",    count,         0);
    check("mr_valid",    bus.out_valid, 0);
    check("mr_data",     bus.out_data,  0);
    check("mr_in_ready", bus.in_ready,  1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
